// File: rtl/uart_tx_arbiter.sv
// Two-requester arbiter in front of a single UART transmitter.
// Bytes are accepted one per UART frame. A message (a run of bytes ending in
// last==1) keeps the transmitter locked to its owner; between messages the
// priority pointer alternates the requesters. A transmitter that never raises
// tx_busy after a start strobe is abandoned after BUSY_TIMEOUT cycles.
module uart_tx_arbiter #(
    parameter int unsigned BUSY_TIMEOUT = 1023
) (
    input  logic       clk,
    input  logic       rst,

    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    input  logic       req0_last,
    output logic       req0_ready,

    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    input  logic       req1_last,
    output logic       req1_ready,

    output logic       tx_start,
    output logic [7:0] tx_data_in,
    input  logic       tx_busy,

    output logic [1:0] grant,
    output logic       timeout_err
);

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWaitRise,
        StWaitFall
    } state_e;

    // Last counter value before the timeout fires.
    localparam logic [15:0] CntLast = 16'(BUSY_TIMEOUT - 1);

    state_e      state_q, state_d;
    logic        owner_q, owner_d;   // 0 = requester 0, 1 = requester 1
    logic        lock_q, lock_d;     // owner is mid-message
    logic        ptr_q, ptr_d;       // requester favoured when both are valid
    logic [15:0] cnt_q, cnt_d;
    logic        tx_start_q, tx_start_d;
    logic [7:0]  tx_data_q, tx_data_d;
    logic [1:0]  grant_q, grant_d;
    logic        timeout_q, timeout_d;

    logic        winner;
    logic        can_accept;
    logic        accept;
    logic [7:0]  acc_data;
    logic        acc_last;

    // Pick the requester that would be served if a byte were accepted now.
    always_comb begin
        winner = 1'b0;
        if (lock_q) begin
            winner = owner_q;
        end else if (req0_valid && req1_valid) begin
            winner = ptr_q;
        end else if (req1_valid) begin
            winner = 1'b1;
        end
    end

    // Ready is combinational so a byte is taken in the same cycle it is offered.
    always_comb begin
        can_accept = (state_q == StIdle) && !tx_busy && !rst;
        req0_ready = can_accept && !winner && req0_valid;
        req1_ready = can_accept && winner && req1_valid;
        accept     = req0_ready || req1_ready;
        acc_data   = winner ? req1_data : req0_data;
        acc_last   = winner ? req1_last : req0_last;
    end

    // Next-state logic for the FSM and all registered outputs.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        lock_d     = lock_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        tx_start_d = 1'b0;
        tx_data_d  = tx_data_q;
        timeout_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    tx_data_d  = acc_data;
                    owner_d    = winner;
                    tx_start_d = 1'b1;
                    state_d    = StIssue;
                    if (acc_last) begin
                        lock_d = 1'b0;
                        ptr_d  = ~winner;
                    end else begin
                        lock_d = 1'b1;
                    end
                end
            end
            StIssue: begin
                cnt_d   = '0;
                state_d = StWaitRise;
            end
            StWaitRise: begin
                if (tx_busy) begin
                    state_d = StWaitFall;
                end else if (cnt_q == CntLast) begin
                    // Transmitter never responded: drop the message and hand
                    // priority to the other side.
                    timeout_d = 1'b1;
                    lock_d    = 1'b0;
                    ptr_d     = ~owner_q;
                    state_d   = StIdle;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            StWaitFall: begin
                if (!tx_busy) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Grant follows the owner while a byte is in flight or a message is open.
        if ((state_d != StIdle) || lock_d) begin
            grant_d = owner_d ? 2'b10 : 2'b01;
        end else begin
            grant_d = 2'b00;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            owner_q    <= 1'b0;
            lock_q     <= 1'b0;
            ptr_q      <= 1'b0;
            cnt_q      <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            grant_q    <= 2'b00;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            lock_q     <= lock_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            tx_start_q <= tx_start_d;
            tx_data_q  <= tx_data_d;
            grant_q    <= grant_d;
            timeout_q  <= timeout_d;
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data_in  = tx_data_q;
    assign grant       = grant_q;
    assign timeout_err = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, round-robin, message lock,
// busy in idle, busy-rise timeout and reset in the middle of a frame.
module tb_uart_tx_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       req0_valid, req0_last, req0_ready;
    logic [7:0] req0_data;
    logic       req1_valid, req1_last, req1_ready;
    logic [7:0] req1_data;
    logic       tx_start, tx_busy, timeout_err;
    logic [7:0] tx_data_in;
    logic [1:0] grant;

    int n_assert = 0;
    int n_fail   = 0;

    uart_tx_arbiter #(.BUSY_TIMEOUT(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_last   (req0_last),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_last   (req1_last),
        .req1_ready  (req1_ready),
        .tx_start    (tx_start),
        .tx_data_in  (tx_data_in),
        .tx_busy     (tx_busy),
        .grant       (grant),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one clock and settle 2 time units past the edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // One complete frame: accept, start strobe, 10-cycle busy, back to idle.
    task automatic do_byte(input string tag, input logic exp_who, input logic [7:0] exp_data);
        int   waited;
        logic who;
        waited = 0;
        #1;
        while (!(req0_ready || req1_ready) && waited < 20) begin
            cyc();
            waited++;
        end
        chk({tag, "_ready_seen"}, 16'(req0_ready || req1_ready), 16'd1);
        who = req1_ready;
        chk({tag, "_winner"}, 16'(who), 16'(exp_who));
        cyc();
        chk({tag, "_tx_start"}, 16'(tx_start), 16'd1);
        chk({tag, "_tx_data"}, 16'(tx_data_in), 16'(exp_data));
        chk({tag, "_grant"}, 16'(grant), exp_who ? 16'd2 : 16'd1);
        cyc();
        chk({tag, "_start_once"}, 16'(tx_start), 16'd0);
        tx_busy = 1'b1;
        repeat (10) cyc();
        tx_busy = 1'b0;
        cyc();
    endtask

    initial begin
        rst        = 1'b1;
        tx_busy    = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h41;
        req0_last  = 1'b1;
        req1_valid = 1'b0;
        req1_data  = 8'hB1;
        req1_last  = 1'b1;

        // Reset: ready held low even though req0 is valid.
        #1;
        chk("rst_ready0", 16'(req0_ready), 16'd0);
        cyc();
        cyc();
        chk("rst_tx_start", 16'(tx_start), 16'd0);
        chk("rst_tx_data", 16'(tx_data_in), 16'h00);
        chk("rst_grant", 16'(grant), 16'd0);
        chk("rst_timeout", 16'(timeout_err), 16'd0);

        // Single byte from req0.
        rst = 1'b0;
        #1;
        chk("single_ready0", 16'(req0_ready), 16'd1);
        chk("single_ready1", 16'(req1_ready), 16'd0);
        cyc();
        chk("single_start", 16'(tx_start), 16'd1);
        chk("single_data", 16'(tx_data_in), 16'h41);
        chk("single_grant", 16'(grant), 16'd1);
        req0_valid = 1'b0;
        cyc();
        chk("single_start_low", 16'(tx_start), 16'd0);
        chk("single_grant_hold", 16'(grant), 16'd1);
        tx_busy = 1'b1;
        cyc();
        cyc();
        tx_busy = 1'b0;
        cyc();
        chk("single_idle_grant", 16'(grant), 16'd0);

        // Round-robin: pointer now at req1 after req0's last byte.
        req0_valid = 1'b1;
        req0_data  = 8'hA0;
        req1_valid = 1'b1;
        do_byte("rr0", 1'b1, 8'hB1);
        do_byte("rr1", 1'b0, 8'hA0);
        do_byte("rr2", 1'b1, 8'hB1);
        do_byte("rr3", 1'b0, 8'hA0);

        // Lock: req0 opens a 3-byte message while req1 waits.
        req1_valid = 1'b0;
        req0_data  = 8'h10;
        req0_last  = 1'b0;
        do_byte("lock_b0", 1'b0, 8'h10);
        chk("lock_idle_grant", 16'(grant), 16'd1);
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        #1;
        chk("lock_r1_blocked", 16'(req1_ready), 16'd0);
        cyc();
        chk("lock_r1_blocked2", 16'(req1_ready), 16'd0);
        chk("lock_idle_grant2", 16'(grant), 16'd1);
        req0_valid = 1'b1;
        req0_data  = 8'h11;
        do_byte("lock_b1", 1'b0, 8'h11);
        chk("lock_idle_grant3", 16'(grant), 16'd1);
        req0_data = 8'h12;
        req0_last = 1'b1;
        do_byte("lock_b2", 1'b0, 8'h12);
        chk("lock_released", 16'(grant), 16'd0);
        do_byte("lock_next", 1'b1, 8'hB1);

        // Busy in idle: req1 must wait until the transmitter is free.
        req0_valid = 1'b0;
        tx_busy    = 1'b1;
        cyc();
        chk("busy_idle_r1", 16'(req1_ready), 16'd0);
        cyc();
        chk("busy_idle_r1b", 16'(req1_ready), 16'd0);
        chk("busy_idle_start", 16'(tx_start), 16'd0);
        tx_busy = 1'b0;
        #1;
        chk("busy_clear_r1", 16'(req1_ready), 16'd1);
        do_byte("busy_accept", 1'b1, 8'hB1);

        // Timeout: req0 opens a message, transmitter never rises.
        req1_valid = 1'b0;
        req0_valid = 1'b1;
        req0_data  = 8'h55;
        req0_last  = 1'b0;
        #1;
        chk("to_ready0", 16'(req0_ready), 16'd1);
        cyc();
        req0_valid = 1'b0;
        cyc();
        for (int k = 1; k < 8; k++) begin
            cyc();
            chk($sformatf("to_quiet_%0d", k), 16'(timeout_err), 16'd0);
        end
        cyc();
        chk("to_pulse", 16'(timeout_err), 16'd1);
        chk("to_grant", 16'(grant), 16'd0);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req1_data  = 8'h66;
        req1_last  = 1'b0;
        #1;
        chk("to_ptr_r1", 16'(req1_ready), 16'd1);
        chk("to_ptr_r0", 16'(req0_ready), 16'd0);
        cyc();
        chk("to_pulse_end", 16'(timeout_err), 16'd0);
        chk("to_next_data", 16'(tx_data_in), 16'h66);

        // Reset in WAIT_FALL with req1 holding the lock.
        cyc();
        tx_busy = 1'b1;
        cyc();
        cyc();
        chk("mid_grant", 16'(grant), 16'd2);
        rst = 1'b1;
        #1;
        chk("mid_rst_r0", 16'(req0_ready), 16'd0);
        chk("mid_rst_r1", 16'(req1_ready), 16'd0);
        cyc();
        chk("mid_tx_start", 16'(tx_start), 16'd0);
        chk("mid_tx_data", 16'(tx_data_in), 16'h00);
        chk("mid_grant_rst", 16'(grant), 16'd0);
        chk("mid_timeout", 16'(timeout_err), 16'd0);
        rst     = 1'b0;
        tx_busy = 1'b0;
        req0_data = 8'hA0;
        req0_last = 1'b1;
        #1;
        chk("post_rst_r0", 16'(req0_ready), 16'd1);
        chk("post_rst_r1", 16'(req1_ready), 16'd0);
        cyc();
        chk("post_rst_data", 16'(tx_data_in), 16'hA0);
        chk("post_rst_grant", 16'(grant), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: BUSY_TIMEOUT, 1023, max cycles in WAIT_RISE for tx_busy to rise after tx_start (legal 1..65535).
REQ-002 Ports: clk  in  1  single clock; all logic on rising edge.
REQ-003 Ports: rst  in  1  synchronous reset, active-high.
REQ-004 Ports: req0_valid  in  1  requester 0 offers a byte.
REQ-005 Ports: req0_data  in  8  requester 0 byte.
REQ-006 Ports: req0_last  in  1  byte ends requester 0 message.
REQ-007 Ports: req0_ready  out  1  requester 0 byte accepted when valid&&ready.
REQ-008 Ports: req1_valid, req1_data, req1_last, req1_ready  same directions/widths/meaning as REQ-004..007, for requester 1.
REQ-009 Ports: tx_start  out  1  one-cycle transmit strobe to the UART transmitter.
REQ-010 Ports: tx_data_in  out  8  byte to the UART transmitter; held stable until the next accept.
REQ-011 Ports: tx_busy  in  1  UART transmitter busy.
REQ-012 Ports: grant  out  2  one-hot current owner (bit0 = req0), 2'b00 when none.
REQ-013 Ports: timeout_err  out  1  one-cycle pulse, tx_busy never rose.

Function
REQ-014 FSM states: IDLE, ISSUE, WAIT_RISE, WAIT_FALL; one transition per cycle max.
REQ-015 Winner in IDLE: locked owner if lock set; else only valid requester; both valid -> requester indicated by priority pointer.
REQ-016 reqN_ready SHALL be combinational: 1 only when state==IDLE, tx_busy==0, rst==0, N==winner, reqN_valid==1; else 0.
REQ-017 While lock set, non-owner ready SHALL stay 0 even when owner valid==0.
REQ-018 Accept (valid&&ready at edge N): tx_data_in<=data, owner<=N, state->ISSUE; tx_start=1 during cycle N+1 only.
REQ-019 ISSUE -> WAIT_RISE unconditionally; timeout counter cleared to 0 on entry to WAIT_RISE.
REQ-020 WAIT_RISE: tx_busy==1 -> WAIT_FALL; else counter+1; counter==BUSY_TIMEOUT-1 with tx_busy==0 -> timeout_err=1 next cycle, lock cleared, pointer to other requester, state->IDLE.
REQ-021 WAIT_FALL: tx_busy==0 -> IDLE; no timeout in WAIT_FALL.
REQ-022 Accepted byte with last==0 sets lock to owner; last==1 clears lock and sets pointer to the other requester.
REQ-023 Priority pointer changes only on last==1 accept or timeout; reset value = requester 0.
REQ-024 grant = owner one-hot in ISSUE, WAIT_RISE, WAIT_FALL, and in IDLE while lock set; 2'b00 otherwise.
REQ-025 IDLE with tx_busy==1 (external/break activity): no accept, hold IDLE.
REQ-026 tx_start, tx_data_in, grant, timeout_err SHALL be registered outputs (ready excepted per REQ-016).
REQ-027 Byte throughput: at most one accept per UART frame; minimum accept-to-accept spacing 4 cycles.

Reset
REQ-028 rst==1 at an edge: state=IDLE, tx_start=0, tx_data_in=8'h00, grant=2'b00, timeout_err=0, lock cleared, counter=0, pointer=requester 0.
REQ-029 rst==1 SHALL force req0_ready=req1_ready=0 combinationally.
REQ-030 rst asserted mid-frame (any state): abandon in-flight byte, no tx_start issued after reset edge, no timeout_err.

Verification
REQ-031 Single: req0 valid data=8'h41 last=1, tx_busy low -> req0_ready=1 same cycle, tx_start=1 next cycle only, tx_data_in=8'h41, grant=2'b01.
REQ-032 Round-robin: both valid last=1 continuously, model busy 10 cycles per byte -> accept order req0,req1,req0,req1; never two consecutive same requester.
REQ-033 Lock: req0 sends 3 bytes last=0,0,1 while req1 valid -> req1_ready=0 until req0 last accepted; next accept is req1; grant=2'b01 throughout req0 message including IDLE gaps.
REQ-034 Timeout: BUSY_TIMEOUT=8, tx_busy held 0 after tx_start -> timeout_err single pulse 8 cycles after WAIT_RISE entry, state IDLE, lock cleared, pointer to req1.
REQ-035 Reset mid-operation: assert rst in WAIT_FALL with lock set -> next cycle all outputs per REQ-028, ready 0 during rst, first post-reset winner with both valid = req0.
REQ-036 Busy in IDLE: tx_busy=1 with req1 valid -> req1_ready=0 until tx_busy=0, then accept same cycle.
